// File: rtl/umtrx_pkt_arbiter.sv
// Packet-boundary arbiter: four 36-bit sources (CPU, ctrl, DSP, error) share one framer path.
// Weighted round-robin between packets, with a strict-priority mask that overrides the rotation.
module umtrx_pkt_arbiter #(
    parameter logic [7:0] BASE  = 8'd0,
    parameter int         WIDTH = 36
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               set_stb,
    input  logic [7:0]         set_addr,
    input  logic [31:0]        set_data,
    input  logic [4*WIDTH-1:0] i_data,
    input  logic [3:0]         i_valid,
    output logic [3:0]         i_ready,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [31:0]        status
);

    // Handshake: a word moves only on a cycle where valid and ready are both high; valid never
    // depends on ready, ready may depend on valid-side state but not the reverse.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        PASS = 2'd2
    } state_t;

    state_t          state;
    logic [3:0][7:0] weights;
    logic [3:0][7:0] credit;
    logic [3:0]      prio_mask;
    logic [1:0]      grant;
    logic [1:0]      rr_ptr;
    logic            rr_fresh;
    logic            prio_pkt;
    logic [7:0]      pkt_cnt;

    logic [WIDTH-1:0] in_word [4];
    logic [3:0]       eligible;
    logic             prio_hit;
    logic [1:0]       prio_sel;
    logic             keep_ok;
    logic             scan_hit;
    logic [1:0]       scan_sel;
    logic [1:0]       scan_start;
    logic [1:0]       scan_idx;
    logic             busy;
    logic             xfer_eof;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            in_word[n]  = i_data[n*WIDTH +: WIDTH];
            eligible[n] = i_valid[n] && (weights[n] != 8'd0);
        end
    end

    always_comb begin
        prio_hit = |(eligible & prio_mask);
        prio_sel = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (eligible[n] && prio_mask[n]) prio_sel = 2'(n);
        end
    end

    // Until the first round-robin grant after reset/clear the scan starts at input 0.
    always_comb begin
        scan_start = rr_fresh ? 2'd0 : rr_ptr + 2'd1;
        scan_hit   = 1'b0;
        scan_sel   = 2'd0;
        scan_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            scan_idx = scan_start + 2'(i);
            if (eligible[scan_idx]) begin
                scan_hit = 1'b1;
                scan_sel = scan_idx;
            end
        end
    end

    assign keep_ok = (credit[rr_ptr] != 8'd0) && eligible[rr_ptr];
    assign busy    = (state == PASS);

    always_comb begin
        o_data  = in_word[grant];
        o_valid = busy && i_valid[grant];
        i_ready = 4'b0000;
        if (busy) i_ready[grant] = o_ready;
    end

    assign xfer_eof = o_valid && o_ready && o_data[33];
    assign status   = {16'd0, pkt_cnt, 2'b00, state, busy, 1'b0, grant};

    always_ff @(posedge clk) begin
        if (reset) begin
            weights   <= {4{8'd1}};
            prio_mask <= 4'b0000;
        end else if (set_stb) begin
            if (set_addr == BASE) weights <= set_data;
            if (set_addr == BASE + 8'd1) prio_mask <= set_data[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state    <= IDLE;
            grant    <= 2'd0;
            rr_ptr   <= 2'd0;
            rr_fresh <= 1'b1;
            credit   <= '0;
            prio_pkt <= 1'b0;
            pkt_cnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: if (|eligible) state <= ARB;
                ARB: begin
                    if (prio_hit) begin
                        grant    <= prio_sel;
                        prio_pkt <= 1'b1;
                        state    <= PASS;
                    end else if (keep_ok) begin
                        grant    <= rr_ptr;
                        prio_pkt <= 1'b0;
                        state    <= PASS;
                    end else if (scan_hit) begin
                        grant            <= scan_sel;
                        rr_ptr           <= scan_sel;
                        rr_fresh         <= 1'b0;
                        credit[scan_sel] <= weights[scan_sel];
                        prio_pkt         <= 1'b0;
                        state            <= PASS;
                    end else begin
                        state <= IDLE;
                    end
                end
                PASS: begin
                    if (xfer_eof) begin
                        // Priority packets ride outside the rotation and leave credit untouched.
                        if (!prio_pkt && credit[grant] != 8'd0)
                            credit[grant] <= credit[grant] - 8'd1;
                        pkt_cnt <= pkt_cnt + 8'd1;
                        state   <= ARB;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_umtrx_pkt_arbiter.sv
// Randomized scoreboard bench for umtrx_pkt_arbiter: a packet-level model predicts the source
// order, expected words are queued at issue time and a monitor checks every output transfer.
module tb_umtrx_pkt_arbiter;

    logic         clk = 1'b0;
    logic         reset, clear, set_stb;
    logic [7:0]   set_addr;
    logic [31:0]  set_data;
    logic [143:0] i_data;
    logic [3:0]   i_valid;
    logic [3:0]   i_ready;
    logic [35:0]  o_data;
    logic         o_valid, o_ready;
    logic [31:0]  status;

    umtrx_pkt_arbiter #(.BASE(8'd0), .WIDTH(36)) dut (
        .clk(clk), .reset(reset), .clear(clear), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
        .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .status(status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [35:0] exp_q[$];
    logic [35:0] src_q[4][$];
    int          got_order[$];
    int          exp_order[$];

    bit mon_en = 1'b1;
    bit gapless = 1'b0;
    bit hold2 = 1'b0;
    int ready_mode = 1;
    bit have_eof = 1'b0;
    int last_eof = 0;
    int eof_seen = 0;
    bit ready2_seen = 1'b0;

    // Packet-level reference: current round-robin owner and turns left in its share.
    int         m_w[4];
    logic [3:0] m_mask;
    int         m_cur;
    int         m_left;
    bit         m_fresh;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input logic [3:0] active, output int s);
        bit elig[4];
        s = -1;
        for (int n = 0; n < 4; n++) elig[n] = active[n] && (m_w[n] != 0);
        for (int n = 0; n < 4; n++) begin
            if (s < 0 && elig[n] && m_mask[n]) s = n;
        end
        if (s >= 0) return;
        if (m_left > 0 && elig[m_cur]) begin
            m_left--;
            s = m_cur;
            return;
        end
        for (int k = 1; k <= 4; k++) begin
            int n;
            n = m_fresh ? (k - 1) : ((m_cur + k) % 4);
            if (s < 0 && elig[n]) s = n;
        end
        if (s >= 0) begin
            m_cur   = s;
            m_left  = m_w[s] - 1;
            m_fresh = 1'b0;
        end
    endtask

    task automatic push_pkt(input int s, input int len);
        logic [35:0] w;
        for (int j = 0; j < len; j++) begin
            w = {s[1:0], (j == len - 1), (j == 0), $urandom()};
            src_q[s].push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic run_pkts(input logic [3:0] active, input int n, input int len);
        int s;
        @(posedge clk); #2;
        for (int k = 0; k < n; k++) begin
            model_step(active, s);
            if (s < 0) break;
            push_pkt(s, (len == 0) ? int'($urandom_range(1, 4)) : len);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            @(posedge clk); #2;
            done = (exp_q.size() == 0) && (src_q[0].size() == 0) && (src_q[1].size() == 0)
                && (src_q[2].size() == 0) && (src_q[3].size() == 0);
        end
        chk("drain_done", 64'(done), 64'd1);
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic set_weights(input logic [31:0] d);
        write_reg(8'd0, d);
        for (int n = 0; n < 4; n++) m_w[n] = int'(d[8*n +: 8]);
    endtask

    task automatic set_prio(input logic [3:0] m);
        write_reg(8'd1, {28'd0, m});
        m_mask = m;
    endtask

    task automatic check_order(input string name);
        chk({name, "_len"}, 64'(got_order.size()), 64'(exp_order.size()));
        for (int i = 0; i < exp_order.size() && i < got_order.size(); i++)
            chk(name, 64'(got_order[i]), 64'(exp_order[i]));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Source drivers and downstream ready: handshake sampled at negedge, queues advance after the edge.
    initial begin
        logic [3:0] acc;
        i_valid = 4'b0000;
        i_data  = '0;
        o_ready = 1'b1;
        forever begin
            @(negedge clk);
            acc = i_valid & i_ready;
            @(posedge clk); #1;
            for (int s = 0; s < 4; s++) begin
                if (acc[s] && !(hold2 && s == 2) && src_q[s].size() > 0) void'(src_q[s].pop_front());
                if (hold2 && s == 2) begin
                    i_valid[s] = 1'b1;
                    i_data[s*36 +: 36] = {2'd2, 2'b11, 32'hdead_beef};
                end else if (src_q[s].size() > 0) begin
                    i_data[s*36 +: 36] = src_q[s][0];
                    i_valid[s] = gapless || src_q[s][0][32] || ($urandom_range(0, 3) != 0);
                end else begin
                    i_valid[s] = 1'b0;
                    i_data[s*36 +: 36] = '0;
                end
            end
            case (ready_mode)
                1: o_ready = 1'b1;
                2: o_ready = !o_ready;
                default: o_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (hold2 && i_ready[2]) ready2_seen = 1'b1;
        if (mon_en && o_valid && o_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 64'(o_data), 64'd0);
            end else begin
                chk("o_data", 64'(o_data), 64'(exp_q.pop_front()));
            end
            chk("grant_matches_src", 64'(status[1:0]), 64'(o_data[35:34]));
            chk("busy_on_xfer", 64'(status[3]), 64'd1);
            if (o_data[32]) begin
                got_order.push_back(int'(o_data[35:34]));
                if (gapless && have_eof) chk("bubble_cycles", 64'(cyc - last_eof), 64'd2);
            end
            if (o_data[33]) begin
                eof_seen++;
                have_eof = 1'b1;
                last_eof = cyc;
            end
        end
    end

    initial begin
        int s;
        bit done;
        reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
        for (int n = 0; n < 4; n++) m_w[n] = 1;
        m_mask = 4'b0000; m_cur = 0; m_left = 0; m_fresh = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #2;
        chk("reset_status", 64'(status), 64'd0);
        chk("reset_o_valid", 64'(o_valid), 64'd0);
        chk("reset_i_ready", 64'(i_ready), 64'd0);

        // Default weights, all four streaming 3-word packets back to back.
        gapless = 1'b1; ready_mode = 1; have_eof = 1'b0; got_order.delete();
        run_pkts(4'b1111, 8, 3);
        wait_drain();
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_order("order_default");
        chk("pkt_cnt_8", 64'(status[15:8]), 64'd8);
        chk("idle_after_drain", 64'(status[5:3]), 64'd0);

        // Input 0 weighted 3, inputs 0 and 1 requesting.
        gapless = 1'b0; ready_mode = 0; got_order.delete();
        set_weights(32'h0101_0103);
        run_pkts(4'b0011, 8, 2);
        wait_drain();
        exp_order = '{0, 0, 0, 1, 0, 0, 0, 1};
        check_order("order_weighted");

        // Weight 0 on input 2 while it holds valid high.
        set_weights(32'h0100_0101);
        hold2 = 1'b1; ready2_seen = 1'b0;
        run_pkts(4'b1111, 12, 0);
        wait_drain();
        chk("weight0_never_ready", 64'(ready2_seen), 64'd0);
        hold2 = 1'b0;

        // Toggling downstream ready across 5-word packets.
        set_weights(32'h0101_0101);
        ready_mode = 2; eof_seen = 0;
        run_pkts(4'b0001, 2, 5);
        wait_drain();
        chk("eof_count_toggle", 64'(eof_seen), 64'd2);

        // Input 1 is priority and requests while input 3 is mid-packet.
        ready_mode = 0; got_order.delete();
        set_prio(4'b0010);
        @(posedge clk); #2;
        model_step(4'b1000, s);
        push_pkt(s, 6);
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(posedge clk); #2;
            done = (exp_q.size() <= 4);
        end
        chk("prio_wait_mid_pkt", 64'(done), 64'd1);
        for (int k = 0; k < 2; k++) begin
            model_step(4'b0010, s);
            push_pkt(s, 3);
        end
        wait_drain();
        exp_order = '{3, 1, 1};
        check_order("order_prio");
        set_prio(4'b0000);
        got_order.delete();
        run_pkts(4'b1111, 4, 2);
        wait_drain();
        exp_order = '{0, 1, 2, 3};
        check_order("order_after_prio");

        // Clear on word 2 of a 4-word packet; settings must survive.
        set_weights(32'h0101_0103);
        gapless = 1'b1; ready_mode = 1; have_eof = 1'b0;
        run_pkts(4'b0011, 2, 4);
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(posedge clk); #2;
            done = (exp_q.size() <= 7);
        end
        chk("clear_wait_word1", 64'(done), 64'd1);
        clear = 1'b1;
        @(posedge clk); #2;
        chk("clear_o_valid", 64'(o_valid), 64'd0);
        chk("clear_state_idle", 64'(status[5:4]), 64'd0);
        chk("clear_pkt_cnt", 64'(status[15:8]), 64'd0);
        clear = 1'b0; mon_en = 1'b0;
        for (int n = 0; n < 4; n++) src_q[n].delete();
        exp_q.delete();
        m_cur = 0; m_left = 0; m_fresh = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        mon_en = 1'b1;
        chk("idle_after_clear", 64'(status[5:3]), 64'd0);
        gapless = 1'b0; ready_mode = 0; got_order.delete();
        run_pkts(4'b0011, 8, 0);
        wait_drain();
        exp_order = '{0, 0, 0, 1, 0, 0, 0, 1};
        check_order("order_after_clear");
        chk("pkt_cnt_after_clear", 64'(status[15:8]), 64'd8);

        // Randomized settings and request sets.
        for (int r = 0; r < 8; r++) begin
            logic [31:0] wr;
            logic [3:0]  act;
            for (int n = 0; n < 4; n++) wr[8*n +: 8] = 8'($urandom_range(0, 3));
            act = 4'($urandom_range(1, 15));
            set_weights(wr);
            set_prio(($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000);
            run_pkts(act, int'($urandom_range(3, 10)), 0);
            wait_drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
